// File: rtl/sid_pkg.sv
// SID shared types and constants for the voice envelope generator.
// Holds the ADSR state encoding, rate period table and exponential period map.
package sid;

    // ADSR phase as seen on the debug port.
    typedef enum logic [1:0] {
        ATTACK        = 2'd0,
        DECAY_SUSTAIN = 2'd1,
        RELEASE       = 2'd2
    } envelope_state_e;

    // Rate counter compare value for each of the 16 register rate codes.
    localparam logic [14:0] RATE_PERIOD [16] = '{
        15'd8,    15'd31,   15'd62,   15'd94,
        15'd148,  15'd219,  15'd266,  15'd312,
        15'd391,  15'd976,  15'd1953, 15'd3125,
        15'd3906, 15'd11719, 15'd19531, 15'd31250
    };

    // Number of rate steps per envelope decrement, by current envelope value.
    // Values above 0x5D behave like 0xFF (one step per decrement).
    function automatic logic [4:0] exp_period(input logic [7:0] env);
        logic [4:0] p;
        if (env == 8'h00) begin
            p = 5'd1;
        end else if (env <= 8'h06) begin
            p = 5'd30;
        end else if (env <= 8'h0E) begin
            p = 5'd16;
        end else if (env <= 8'h1A) begin
            p = 5'd8;
        end else if (env <= 8'h36) begin
            p = 5'd4;
        end else if (env <= 8'h5D) begin
            p = 5'd2;
        end else begin
            p = 5'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/sid_envelope.sv
// Per-voice SID ADSR envelope generator: rate counter, exponential
// counter and attack/decay-sustain/release state machine, advanced on ce.
module sid_envelope
    import sid::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       gate,
    input  logic [7:0] attack_decay,
    input  logic [7:0] sustain_release,
    output logic [7:0] envelope_o,
    output logic [1:0] state_o
);

    envelope_state_e state_q, state_d;
    logic [7:0]      env_q, env_d;
    logic [14:0]     rate_cnt_q, rate_cnt_d;
    logic [4:0]      exp_cnt_q, exp_cnt_d;
    logic            hold_zero_q, hold_zero_d;
    logic            gate_prev_q, gate_prev_d;

    logic [3:0]      rate_sel;
    logic [14:0]     rate_period;
    logic            rate_step;
    logic [4:0]      exp_next;
    logic            exp_step;
    logic            decay_ok;
    logic [7:0]      sustain_level;

    assign sustain_level = {sustain_release[7:4], sustain_release[7:4]};

    // Next-state logic: gate edges first, then the rate/exponential step
    // evaluated against the post-edge state.
    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        rate_cnt_d  = rate_cnt_q;
        exp_cnt_d   = exp_cnt_q;
        hold_zero_d = hold_zero_q;
        gate_prev_d = gate_prev_q;
        rate_sel    = 4'd0;
        rate_period = 15'd0;
        rate_step   = 1'b0;
        exp_next    = 5'd0;
        exp_step    = 1'b0;
        decay_ok    = 1'b0;

        if (ce) begin
            gate_prev_d = gate;
            if (gate && !gate_prev_q) begin
                state_d     = ATTACK;
                hold_zero_d = 1'b0;
            end else if (!gate && gate_prev_q) begin
                state_d = RELEASE;
            end

            unique case (state_d)
                ATTACK:        rate_sel = attack_decay[7:4];
                DECAY_SUSTAIN: rate_sel = attack_decay[3:0];
                default:       rate_sel = sustain_release[3:0];
            endcase
            rate_period = RATE_PERIOD[rate_sel];

            // Equality compare only: a lowered period makes the counter
            // run through 0x7FFF and wrap before it can match again.
            if (rate_cnt_q == rate_period) begin
                rate_cnt_d = 15'd0;
                rate_step  = 1'b1;
            end else begin
                rate_cnt_d = rate_cnt_q + 15'd1;
            end

            if (rate_step) begin
                if (state_d == ATTACK) begin
                    if (!hold_zero_d) begin
                        if (env_q != 8'hFF) begin
                            env_d = env_q + 8'd1;
                        end
                        if (env_q >= 8'hFE) begin
                            state_d = DECAY_SUSTAIN;
                        end
                    end
                end else begin
                    exp_next = exp_cnt_q + 5'd1;
                    if (exp_next >= exp_period(env_q)) begin
                        exp_cnt_d = 5'd0;
                        exp_step  = 1'b1;
                    end else begin
                        exp_cnt_d = exp_next;
                    end
                end
            end

            decay_ok = (state_d == RELEASE) || (env_q > sustain_level);
            if (exp_step && !hold_zero_d && decay_ok) begin
                if (env_q != 8'h00) begin
                    env_d = env_q - 8'd1;
                end
                if (env_q <= 8'h01) begin
                    hold_zero_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset that overrides ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RELEASE;
            env_q       <= 8'h00;
            rate_cnt_q  <= 15'd0;
            exp_cnt_q   <= 5'd0;
            hold_zero_q <= 1'b1;
            gate_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            env_q       <= env_d;
            rate_cnt_q  <= rate_cnt_d;
            exp_cnt_q   <= exp_cnt_d;
            hold_zero_q <= hold_zero_d;
            gate_prev_q <= gate_prev_d;
        end
    end

    assign envelope_o = env_q;
    assign state_o    = state_q;

endmodule

// File: doc/sid_envelope.md
# sid_envelope

Per-voice ADSR envelope generator for the MOS6581/8580 emulation. It sits directly upstream of the voice DCA stage and produces the 8-bit envelope value (`voice_i.envelope`) that the DCA multiplies with the selected waveform. It models the SID rate counter, the piecewise-exponential decay/release counter and the ADSR state machine, and advances once per SID cycle under a clock enable.

## Interface
- No parameters. Rate and exponential period tables are package constants.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous and active-high.
- `ce`  in  1  SID-cycle enable (phi2). All state advances only on cycles where `ce`=1.
- `gate`  in  1  control register gate bit.
- `attack_decay`  in  8  register: [7:4] attack, [3:0] decay.
- `sustain_release`  in  8  register: [7:4] sustain level, [3:0] release.
- `envelope_o`  out  8  envelope value, registered; feeds `voice_i.envelope`.
- `state_o`  out  2  `sid::envelope_state_e`, registered, for debug/verification.

## Operation
- States: ATTACK, DECAY_SUSTAIN, RELEASE. `gate_prev` holds `gate` as of the last `ce`.
- Gate edges are evaluated on `ce` cycles only.
  - Rising edge (gate=1, gate_prev=0): go to ATTACK from any state, and clear `hold_zero`.
  - Falling edge: go to RELEASE from any state.
- Rate select: ATTACK uses `attack_decay[7:4]`, DECAY_SUSTAIN uses `attack_decay[3:0]`, RELEASE uses `sustain_release[3:0]`.
- Rate period table (compare values) for rates 0..15: 8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31250.
- Rate counter: 15 bits, incremented on each `ce`.
  - When it equals the selected period, it resets to 0 and issues a rate step.
  - If the period is lowered below the current count, the counter runs on to 0x7FFF, wraps to 0, and only then matches. This reproduces the real-chip ADSR delay.
- Exponential counter: 5 bits, reset to 0 on each period match.
  - Period by envelope value: 0xFF→1, ≤0x5D→2, ≤0x36→4, ≤0x1A→8, ≤0x0E→16, ≤0x06→30, 0x00→1.
  - The period is re-evaluated whenever the envelope value changes.
- Steps:
  - ATTACK: every rate step increments the envelope (the exponential counter is bypassed). On reaching 0xFF, go to DECAY_SUSTAIN in the same step.
  - DECAY_SUSTAIN: a rate step advances the exponential counter. On an exponential match, decrement the envelope, but only while envelope > {sustain, sustain}. At or below the sustain level the envelope holds.
  - RELEASE: same as decay, with no sustain floor.
- Zero floor: when a decrement yields 0, set `hold_zero`. While `hold_zero` is set, the envelope does not change until the next gate rising edge.
- Simultaneous gate edge and rate step on the same `ce`: the new state applies, and the step is evaluated against the new state.

## Timing
- Reset values: `envelope_o`=0, `state_o`=RELEASE, rate counter 0, exponential counter 0, `hold_zero`=1, `gate_prev`=0.
- `rst` overrides `ce`. Reset mid-envelope returns to the reset values on the next `clk`.
- Latency: a change on `ce` cycle N is visible on `envelope_o`/`state_o` after the `clk` edge ending cycle N (1 clk).
- Outputs are stable between `ce` pulses.
- Register inputs are sampled only on `ce` cycles. Changes between pulses have no effect until the next `ce`.
- Arithmetic: the envelope is an 8-bit unsigned value that never wraps; increments clamp at 0xFF and decrements at 0x00.

## Structure
- `sid` package additions:
  - `envelope_state_e` (2-bit enum).
  - Rate period constant array (16 × 15 bits).
  - A function mapping envelope value → exponential period.
- No sub-module. This is a single FSM with two counters and comparators.

## Test plan
- Attack 0, gate 0→1 after reset → `envelope_o` becomes 0x01 exactly 9 `ce` pulses later. It reaches 0xFF after 255×9 pulses, then `state_o`=DECAY_SUSTAIN.
- Decay 0, sustain 0x8, starting at 0xFF → envelope decrements once per 9 `ce` pulses and holds at 0x88 indefinitely.
- Gate 1→0 at sustain 0x88, release 0 → envelope falls with exponential periods (2 at ≤0x5D, 30 at ≤0x06) and stops at 0x00 with `hold_zero` set. A further 10000 pulses produce no change.
- Delay bug: release rate 15 for 1000 pulses, then switch to rate 0 → the next step occurs only after the counter wraps past 0x7FFF (32768 − 1000 + 9 pulses).
- Gate retriggered mid-release at envelope 0x40 → ATTACK resumes upward from 0x40, not 0.
- `rst` asserted mid-attack with `ce` held high → next cycle `envelope_o`=0, `state_o`=RELEASE. Pulses with `ce`=0 never change the outputs.
